// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with one write port and two
// combinational read ports.
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high; clears every register, beats any write
//   wrenable    write request for the current cycle
//   writeaddr   target register of the write
//   writedata   write data
//   byteenable  per-byte write mask, bit i covers writedata[8i+7:8i]
//   readaddr1/2 read port addresses
//   readdata1/2 read port data, combinational from address and state
//
// Parameters:
//   WIDTH     data width, multiple of 8, at least 8
//   DEPTH     register count, power of two, at least 2
//   ADDR_W    log2(DEPTH)
//   ZERO_REG  1: register 0 reads as zero and ignores writes
//   BYPASS    1: a read hitting the register being written returns the merged
//             value that the edge is about to store

module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wrenable,
    input  logic [ADDR_W-1:0]    writeaddr,
    input  logic [WIDTH-1:0]     writedata,
    input  logic [WIDTH/8-1:0]   byteenable,
    input  logic [ADDR_W-1:0]    readaddr1,
    input  logic [ADDR_W-1:0]    readaddr2,
    output logic [WIDTH-1:0]     readdata1,
    output logic [WIDTH-1:0]     readdata2
);

    localparam int NBYTES = WIDTH / 8;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] bytemask;
    logic [WIDTH-1:0] write_merged;
    logic             write_hits_zero;
    logic             write_commit;
    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;
    logic             bypass1;
    logic             bypass2;

    // Bit-level expansion of byteenable so merging is a single and/or.
    always_comb begin
        bytemask = '0;
        for (int i = 0; i < NBYTES; i++) begin
            bytemask[8*i +: 8] = {8{byteenable[i]}};
        end
    end

    // Value the target register takes on a write; also what bypass forwards.
    assign write_merged = (regs[writeaddr] & ~bytemask) | (writedata & bytemask);

    assign write_hits_zero = (ZERO_REG != 0) && (writeaddr == '0);
    assign write_commit    = wrenable && !write_hits_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_commit) begin
            regs[writeaddr] <= write_merged;
        end
    end

    // Register 0 is forced to zero on the read side as well, so it never
    // shows X even before the first reset.
    assign stored1 = ((ZERO_REG != 0) && (readaddr1 == '0)) ? '0 : regs[readaddr1];
    assign stored2 = ((ZERO_REG != 0) && (readaddr2 == '0)) ? '0 : regs[readaddr2];

    // Bypass only when the write will actually land: no reset, and not the
    // hard-wired zero register.
    assign bypass1 = (BYPASS != 0) && wrenable && !reset && !write_hits_zero &&
                     (readaddr1 == writeaddr);
    assign bypass2 = (BYPASS != 0) && wrenable && !reset && !write_hits_zero &&
                     (readaddr2 == writeaddr);

    assign readdata1 = bypass1 ? write_merged : stored1;
    assign readdata2 = bypass2 ? write_merged : stored2;

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param. Three instances share clk and reset:
//   u_a : defaults (WIDTH=32, DEPTH=32, ZERO_REG=1, BYPASS=1)
//   u_b : WIDTH=32, DEPTH=32, ZERO_REG=0, BYPASS=0 (driven with the same stimulus as u_a)
//   u_s : WIDTH=16, DEPTH=8, defaults otherwise
// Directed scenarios use literal expectations; random traffic is checked
// against array models updated by the plain write/reset rules.

module tb_regfile_param;

    logic        clk;
    logic        reset;

    logic        wrenable;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [4:0]  readaddr1;
    logic [4:0]  readaddr2;
    logic [31:0] rd_a1, rd_a2, rd_b1, rd_b2;

    logic        s_wrenable;
    logic [2:0]  s_writeaddr;
    logic [15:0] s_writedata;
    logic [1:0]  s_byteenable;
    logic [2:0]  s_readaddr1;
    logic [2:0]  s_readaddr2;
    logic [15:0] rd_s1, rd_s2;

    int ntests;
    int nfail;

    logic [31:0] m_a [32];
    logic [31:0] m_b [32];
    logic [15:0] m_s [8];

    regfile_param u_a (
        .clk(clk), .reset(reset), .wrenable(wrenable), .writeaddr(writeaddr),
        .writedata(writedata), .byteenable(byteenable),
        .readaddr1(readaddr1), .readaddr2(readaddr2),
        .readdata1(rd_a1), .readdata2(rd_a2)
    );

    regfile_param #(.ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .wrenable(wrenable), .writeaddr(writeaddr),
        .writedata(writedata), .byteenable(byteenable),
        .readaddr1(readaddr1), .readaddr2(readaddr2),
        .readdata1(rd_b1), .readdata2(rd_b2)
    );

    regfile_param #(.WIDTH(16), .DEPTH(8)) u_s (
        .clk(clk), .reset(reset), .wrenable(s_wrenable), .writeaddr(s_writeaddr),
        .writedata(s_writedata), .byteenable(s_byteenable),
        .readaddr1(s_readaddr1), .readaddr2(s_readaddr2),
        .readdata1(rd_s1), .readdata2(rd_s2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                            input logic [15:0] new_v,
                                            input logic [1:0]  be);
        logic [15:0] r;
        for (int b = 0; b < 2; b++) begin
            r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_a(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wrenable && !reset && a == writeaddr)
            return merge32(m_a[a], writedata, byteenable);
        return m_a[a];
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] a);
        return m_b[a];
    endfunction

    function automatic logic [15:0] exp_s(input logic [2:0] a);
        if (a == 3'd0) return 16'h0;
        if (s_wrenable && !reset && a == s_writeaddr)
            return merge16(m_s[a], s_writedata, s_byteenable);
        return m_s[a];
    endfunction

    // Advance one clock edge, applying the same edge to the models, then
    // settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_a[i] = '0;
                m_b[i] = '0;
            end
            for (int i = 0; i < 8; i++) m_s[i] = '0;
        end else begin
            if (wrenable) begin
                if (writeaddr != 5'd0) m_a[writeaddr] = merge32(m_a[writeaddr], writedata, byteenable);
                m_b[writeaddr] = merge32(m_b[writeaddr], writedata, byteenable);
            end
            if (s_wrenable && s_writeaddr != 3'd0)
                m_s[s_writeaddr] = merge16(m_s[s_writeaddr], s_writedata, s_byteenable);
        end
        #1;
    endtask

    task automatic idle_inputs();
        wrenable = 0; writeaddr = 0; writedata = 0; byteenable = 0;
        s_wrenable = 0; s_writeaddr = 0; s_writedata = 0; s_byteenable = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1;
        wrenable = 1; writeaddr = 5'd9; writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
        tick();
        reset = 0;
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            readaddr1 = 5'(i); readaddr2 = 5'(31 - i);
            #1;
            ntests++;
            if (rd_a1 !== 32'h0 || rd_a2 !== 32'h0) begin
                nfail++;
                $display("FAIL reset_a addr=%0d got=%h/%h exp=0", i, rd_a1, rd_a2);
            end
            ntests++;
            if (rd_b1 !== 32'h0 || rd_b2 !== 32'h0) begin
                nfail++;
                $display("FAIL reset_b addr=%0d got=%h/%h exp=0", i, rd_b1, rd_b2);
            end
        end
        for (int i = 0; i < 8; i++) begin
            s_readaddr1 = 3'(i); s_readaddr2 = 3'(7 - i);
            #1;
            ntests++;
            if (rd_s1 !== 16'h0 || rd_s2 !== 16'h0) begin
                nfail++;
                $display("FAIL reset_s addr=%0d got=%h/%h exp=0", i, rd_s1, rd_s2);
            end
        end
    endtask

    task automatic test_basic_write();
        wrenable = 1; writeaddr = 5'd5; writedata = 32'hDEAD_BEEF; byteenable = 4'hF;
        tick();
        idle_inputs();
        readaddr1 = 5'd5; readaddr2 = 5'd6;
        #1;
        ntests++;
        if (rd_a1 !== 32'hDEAD_BEEF) begin
            nfail++; $display("FAIL basic_r5 got=%h exp=deadbeef", rd_a1);
        end
        ntests++;
        if (rd_a2 !== 32'h0) begin
            nfail++; $display("FAIL basic_r6 got=%h exp=0", rd_a2);
        end
        ntests++;
        if (rd_b1 !== 32'hDEAD_BEEF) begin
            nfail++; $display("FAIL basic_b_r5 got=%h exp=deadbeef", rd_b1);
        end
    endtask

    task automatic test_byte_merge();
        wrenable = 1; writeaddr = 5'd5; writedata = 32'h1122_3344; byteenable = 4'h5;
        readaddr1 = 5'd5; readaddr2 = 5'd5;
        #1;
        ntests++;
        if (rd_a1 !== 32'hDE22_BE44 || rd_a2 !== 32'hDE22_BE44) begin
            nfail++; $display("FAIL merge_bypass got=%h/%h exp=de22be44", rd_a1, rd_a2);
        end
        ntests++;
        if (rd_b1 !== 32'hDEAD_BEEF || rd_b2 !== 32'hDEAD_BEEF) begin
            nfail++; $display("FAIL merge_nobypass got=%h/%h exp=deadbeef", rd_b1, rd_b2);
        end
        tick();
        idle_inputs();
        #1;
        ntests++;
        if (rd_a1 !== 32'hDE22_BE44 || rd_b1 !== 32'hDE22_BE44) begin
            nfail++; $display("FAIL merge_stored got=%h/%h exp=de22be44", rd_a1, rd_b1);
        end
        // all-zero byteenable changes nothing
        wrenable = 1; writeaddr = 5'd5; writedata = 32'h0; byteenable = 4'h0;
        tick();
        idle_inputs();
        #1;
        ntests++;
        if (rd_a1 !== 32'hDE22_BE44 || rd_b1 !== 32'hDE22_BE44) begin
            nfail++; $display("FAIL merge_be0 got=%h/%h exp=de22be44", rd_a1, rd_b1);
        end
    endtask

    task automatic test_zero_reg();
        wrenable = 1; writeaddr = 5'd0; writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
        readaddr1 = 5'd0; readaddr2 = 5'd0;
        #1;
        ntests++;
        if (rd_a1 !== 32'h0 || rd_a2 !== 32'h0) begin
            nfail++; $display("FAIL zero_during got=%h/%h exp=0", rd_a1, rd_a2);
        end
        tick();
        idle_inputs();
        #1;
        ntests++;
        if (rd_a1 !== 32'h0) begin
            nfail++; $display("FAIL zero_after got=%h exp=0", rd_a1);
        end
        ntests++;
        if (rd_b1 !== 32'hFFFF_FFFF) begin
            nfail++; $display("FAIL zero_off_after got=%h exp=ffffffff", rd_b1);
        end
    endtask

    task automatic test_no_bypass();
        wrenable = 1; writeaddr = 5'd7; writedata = 32'h1; byteenable = 4'hF;
        tick();
        writedata = 32'h2; readaddr1 = 5'd7; readaddr2 = 5'd3;
        #1;
        ntests++;
        if (rd_b1 !== 32'h1) begin
            nfail++; $display("FAIL nobyp_during got=%h exp=00000001", rd_b1);
        end
        ntests++;
        if (rd_a1 !== 32'h2) begin
            nfail++; $display("FAIL byp_during got=%h exp=00000002", rd_a1);
        end
        tick();
        idle_inputs();
        #1;
        ntests++;
        if (rd_b1 !== 32'h2 || rd_a1 !== 32'h2) begin
            nfail++; $display("FAIL nobyp_after got=%h/%h exp=00000002", rd_b1, rd_a1);
        end
    endtask

    task automatic test_reset_priority();
        wrenable = 1; writeaddr = 5'd3; writedata = 32'hA5A5_A5A5; byteenable = 4'hF;
        tick();
        reset = 1; writedata = 32'h1234_5678; readaddr1 = 5'd3; readaddr2 = 5'd3;
        #1;
        ntests++;
        if (rd_a1 !== 32'hA5A5_A5A5 || rd_a2 !== 32'hA5A5_A5A5) begin
            nfail++; $display("FAIL rstpri_nobypass got=%h/%h exp=a5a5a5a5", rd_a1, rd_a2);
        end
        tick();
        reset = 0;
        idle_inputs();
        #1;
        ntests++;
        if (rd_a1 !== 32'h0 || rd_b1 !== 32'h0) begin
            nfail++; $display("FAIL rstpri_cleared got=%h/%h exp=0", rd_a1, rd_b1);
        end
        wrenable = 1; writeaddr = 5'd3; writedata = 32'hCAFE_F00D; byteenable = 4'hF;
        tick();
        idle_inputs();
        #1;
        ntests++;
        if (rd_a1 !== 32'hCAFE_F00D || rd_b1 !== 32'hCAFE_F00D) begin
            nfail++; $display("FAIL rst_then_write got=%h/%h exp=cafef00d", rd_a1, rd_b1);
        end
    endtask

    task automatic test_small_width();
        s_wrenable = 1; s_writeaddr = 3'd7; s_writedata = 16'hBEEF; s_byteenable = 2'b10;
        tick();
        idle_inputs();
        s_readaddr1 = 3'd7;
        s_readaddr2 = s_readaddr1 + 3'd1;
        #1;
        ntests++;
        if (rd_s1 !== 16'hBE00) begin
            nfail++; $display("FAIL small_r7 got=%h exp=be00", rd_s1);
        end
        ntests++;
        if (rd_s2 !== 16'h0) begin
            nfail++; $display("FAIL small_wrap got=%h exp=0", rd_s2);
        end
    endtask

    // Random traffic on all three instances, each cycle checked before the
    // edge (bypass visible) against the models. Addresses are often drawn
    // from a small range so reads collide with writes frequently.
    task automatic test_back_to_back();
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 49) == 0);
            wrenable     = ($urandom_range(0, 3) != 0);
            writeaddr    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            writedata    = $urandom;
            byteenable   = 4'($urandom);
            readaddr1    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            readaddr2    = ($urandom_range(0, 3) == 0) ? readaddr1 : 5'($urandom_range(0, 3));
            s_wrenable   = ($urandom_range(0, 3) != 0);
            s_writeaddr  = 3'($urandom);
            s_writedata  = 16'($urandom);
            s_byteenable = 2'($urandom);
            s_readaddr1  = 3'($urandom);
            s_readaddr2  = 3'($urandom);
            #1;
            ntests++;
            if (rd_a1 !== exp_a(readaddr1) || rd_a2 !== exp_a(readaddr2)) begin
                nfail++;
                $display("FAIL rand_a n=%0d ra=%0d/%0d got=%h/%h exp=%h/%h", n, readaddr1, readaddr2,
                         rd_a1, rd_a2, exp_a(readaddr1), exp_a(readaddr2));
            end
            ntests++;
            if (rd_b1 !== exp_b(readaddr1) || rd_b2 !== exp_b(readaddr2)) begin
                nfail++;
                $display("FAIL rand_b n=%0d ra=%0d/%0d got=%h/%h exp=%h/%h", n, readaddr1, readaddr2,
                         rd_b1, rd_b2, exp_b(readaddr1), exp_b(readaddr2));
            end
            ntests++;
            if (rd_s1 !== exp_s(s_readaddr1) || rd_s2 !== exp_s(s_readaddr2)) begin
                nfail++;
                $display("FAIL rand_s n=%0d ra=%0d/%0d got=%h/%h exp=%h/%h", n, s_readaddr1, s_readaddr2,
                         rd_s1, rd_s2, exp_s(s_readaddr1), exp_s(s_readaddr2));
            end
            tick();
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        ntests = 0;
        nfail  = 0;
        reset  = 1;
        readaddr1 = 0; readaddr2 = 0; s_readaddr1 = 0; s_readaddr2 = 0;
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            m_a[i] = '0;
            m_b[i] = '0;
        end
        for (int i = 0; i < 8; i++) m_s[i] = '0;
        #2;

        test_reset();
        test_basic_write();
        test_byte_merge();
        test_zero_reg();
        test_no_bypass();
        test_reset_priority();
        test_back_to_back();
        test_reset();
        test_small_width();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
